// File: rtl/flag_gen_unit.sv
// flag_gen_unit: multi-cycle chunked a-b comparator producing s/z/c/v branch flags.
module flag_gen_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             valid,
  output logic             s,
  output logic             z,
  output logic             c,
  output logic             v
);
  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, CALC} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b;
  logic [KW-1:0]    r_k;
  logic             r_cy, r_zr, r_valid, r_s, r_z, r_c, r_v;
  logic [CHUNK-1:0] w_ca, w_cb, w_sum;
  logic             w_co, w_last, w_go;

  assign w_ca          = r_a[r_k*CHUNK +: CHUNK];
  assign w_cb          = r_b[r_k*CHUNK +: CHUNK];
  assign {w_co, w_sum} = {1'b0, w_ca} + {1'b0, ~w_cb} + {{CHUNK{1'b0}}, r_cy};
  assign w_last        = (r_k == KW'(N - 1));
  assign w_go          = (r_state == IDLE) && start && !flush;

  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && w_go) w_next = CALC;
    if (r_state == CALC && (flush || w_last)) w_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_k     <= '0;
      r_cy    <= 1'b0;
      r_zr    <= 1'b0;
      r_valid <= 1'b0;
      r_s     <= 1'b0;
      r_z     <= 1'b0;
      r_c     <= 1'b0;
      r_v     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_go) begin
        r_a  <= a;
        r_b  <= b;
        r_k  <= '0;
        r_cy <= 1'b1;
        r_zr <= 1'b1;
      end else if (r_state == CALC && !flush) begin
        r_cy <= w_co;
        r_zr <= r_zr & (w_sum == '0);
        r_k  <= r_k + KW'(1);
        if (w_last) begin
          r_s     <= w_sum[CHUNK-1];
          r_z     <= r_zr & (w_sum == '0);
          r_c     <= w_co;
          r_v     <= (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_sum[CHUNK-1] != r_a[WIDTH-1]);
          r_valid <= 1'b1;
        end
      end
    end
  end

  assign busy  = (r_state == CALC);
  assign valid = r_valid;
  assign s     = r_s;
  assign z     = r_z;
  assign c     = r_c;
  assign v     = r_v;
endmodule

// File: tb/tb_flag_gen_unit.sv
// tb_flag_gen_unit: table, random and corner-sequence checks of flag_gen_unit.
module tb_flag_gen_unit;
  localparam int N = 4;

  logic        clk, rst, start, flush;
  logic [31:0] a, b;
  logic        busy, valid, s, z, c, v;
  int          n_vec, n_bad;

  flag_gen_unit #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .a(a), .b(b),
    .busy(busy), .valid(valid), .s(s), .z(z), .c(c), .v(v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  f;
  } vec_t;

  function automatic logic [3:0] model(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] d;
    d = x - y;
    return {d[31], d == 32'd0, x >= y, (x[31] != y[31]) && (d[31] != x[31])};
  endfunction

  task automatic check(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb, input logic [3:0] ef);
    @(negedge clk);
    start = 1'b1; a = ta; b = tb;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    for (int i = 0; i < N; i++) begin
      check("busy_phase", {6'd0, busy, valid}, 8'b10);
      @(negedge clk);
    end
    check("valid_phase", {6'd0, busy, valid}, 8'b01);
    check("flags", {4'd0, s, z, c, v}, {4'd0, ef});
  endtask

  vec_t tbl[8];

  initial begin
    int cnt;
    logic [31:0] ra, rb;
    n_vec = 0; n_bad = 0;
    start = 0; flush = 0; a = 0; b = 0; rst = 0;
    tbl[0] = '{32'h00000005, 32'h00000005, 4'b0110};
    tbl[1] = '{32'h00000001, 32'h00000002, 4'b1000};
    tbl[2] = '{32'h00000100, 32'h00000001, 4'b0010};
    tbl[3] = '{32'h80000000, 32'h00000001, 4'b0011};
    tbl[4] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 4'b1001};
    tbl[5] = '{32'h00000000, 32'h00000000, 4'b0110};
    tbl[6] = '{32'hFFFFFFFF, 32'h00000000, 4'b1010};
    tbl[7] = '{32'h00000000, 32'h00000001, 4'b1000};
    #3;
    check("reset_outputs", {2'd0, busy, valid, s, z, c, v}, 8'd0);
    @(negedge clk);
    rst = 1;
    foreach (tbl[i]) do_op(tbl[i].a, tbl[i].b, tbl[i].f);
    for (int i = 0; i < 200; i++) begin
      ra = $urandom; rb = $urandom;
      if (i % 10 == 0) rb = ra;
      if (i % 10 == 1) rb = {ra[31:8], 8'($urandom)};
      do_op(ra, rb, model(ra, rb));
    end
    do_op(32'h5, 32'h5, 4'b0110);
    @(negedge clk);
    start = 1; a = 32'h1; b = 32'h2;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    check("flush_busy_valid", {6'd0, busy, valid}, 8'b00);
    check("flush_flags", {4'd0, s, z, c, v}, 8'b0110);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("flush_no_valid", {6'd0, busy, valid}, 8'b00);
    end
    start = 1; a = 32'h3; b = 32'h7;
    @(negedge clk);
    a = 32'h9; b = 32'h9;
    @(negedge clk);
    @(negedge clk);
    start = 0;
    @(negedge clk);
    @(negedge clk);
    check("ignored_start_valid", {6'd0, busy, valid}, 8'b01);
    check("ignored_start_flags", {4'd0, s, z, c, v}, {4'd0, model(32'h3, 32'h7)});
    start = 1; a = 32'h1; b = 32'h2;
    @(negedge clk);
    start = 0; a = 0; b = 0;
    cnt = 1;
    while (!valid && cnt < 12) begin
      @(negedge clk);
      cnt++;
    end
    check("b2b_spacing", 8'(cnt), 8'd5);
    check("b2b_flags", {4'd0, s, z, c, v}, 8'b1000);
    @(negedge clk);
    start = 1; a = 32'h80000000; b = 32'h1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    check("reset_mid_op", {2'd0, busy, valid, s, z, c, v}, 8'd0);
    #2;
    rst = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_reset_idle", {6'd0, busy, valid}, 8'b00);
    end
    do_op(32'h80000000, 32'h1, 4'b0011);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
